// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem_responder line-memory model.
// Consumed by pmem_array and pmem_responder.
package pmem_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/pmem_array.sv
// Line storage: 2**IDX_W lines of LINE_W bits, one synchronous write port,
// one combinational read port. Contents are deliberately not reset.
module pmem_array
    import pmem_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LINE_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [LINE_W-1:0] rd_data
);

    logic [LINE_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line memory responder: IDLE -> ACCESS (LATENCY cycles) -> RESP.
// Optional protocol checker driving prot_err is enabled by PMEM_PROTO_CHECK_EN.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int LATENCY = 8,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              prot_err
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    op_t               op;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] line;
    logic              accept;
    logic              last_access;
    logic              wr_en;

    // Exactly one request is a legal request; both together are refused.
    assign accept      = pmem_read ^ pmem_write;
    assign last_access = (state == ST_ACCESS) && (cnt == LAST);
    // Gated by state, so an asynchronous reset mid-ACCESS can never commit.
    assign wr_en       = last_access && (op == OP_WRITE);

    pmem_array #(
        .IDX_W(IDX_W)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (idx),
        .wr_data(wdata_q),
        .rd_idx (idx),
        .rd_data(line)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            op         <= OP_READ;
            wdata_q    <= '0;
            pmem_rdata <= '0;
            pmem_resp  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pmem_resp <= 1'b0;
                    if (accept) begin
                        idx     <= pmem_address[IDX_W+OFFSET_W-1:OFFSET_W];
                        op      <= pmem_write ? OP_WRITE : OP_READ;
                        wdata_q <= pmem_wdata;
                        cnt     <= LOAD;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt - LAST;
                    if (cnt == LAST) begin
                        state     <= ST_RESP;
                        pmem_resp <= 1'b1;
                        if (op == OP_READ) begin
                            pmem_rdata <= line;
                        end
                    end
                end
                ST_RESP: begin
                    pmem_resp <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    pmem_resp <= 1'b0;
                    cnt       <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PMEM_PROTO_CHECK_EN
    logic [31:0] addr_q;
    logic        held;
    logic        busy;

    assign held = (op == OP_READ) ? pmem_read : pmem_write;
    assign busy = (state == ST_ACCESS) || (state == ST_RESP);

    // Sticky until reset: the requester must hold its request and address
    // stable from acceptance through the response cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            prot_err <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && accept) begin
                addr_q <= pmem_address;
            end
            if ((pmem_read && pmem_write) ||
                (busy && (!held || (pmem_address != addr_q)))) begin
                prot_err <= 1'b1;
            end
        end
    end
`else
    assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a LATENCY=8 instance plus a LATENCY=1 instance.
module tb_pmem_responder;

    localparam bit CHECK_EN =
`ifdef PMEM_PROTO_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    localparam logic [255:0] D_A5 = {32{8'hA5}};
    localparam logic [255:0] D_P3 = {8{32'h1234_5678}};
    localparam logic [255:0] D_WB = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] D_FF = {256{1'b1}};
    localparam logic [255:0] D_L1 = {16{16'hC3E1}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  pmem_address = '0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         prot_err;

    logic [31:0]  l1_address = '0;
    logic         l1_read = 1'b0;
    logic         l1_write = 1'b0;
    logic [255:0] l1_wdata = '0;
    logic [255:0] l1_rdata;
    logic         l1_resp;
    logic         l1_prot_err;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int t_start;
    int t_first;
    int at;

    pmem_responder #(.LATENCY(8), .IDX_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pmem_address(pmem_address),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .prot_err    (prot_err)
    );

    pmem_responder #(.LATENCY(1), .IDX_W(4)) dut_l1 (
        .clk         (clk),
        .rst         (rst),
        .pmem_address(l1_address),
        .pmem_read   (l1_read),
        .pmem_write  (l1_write),
        .pmem_wdata  (l1_wdata),
        .pmem_rdata  (l1_rdata),
        .pmem_resp   (l1_resp),
        .prot_err    (l1_prot_err)
    );

    // Clock and cycle index: cyc equals n throughout the cycle after posedge n.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [255:0] d);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = a;
        pmem_wdata   = d;
        t_start      = cyc;
    endtask

    // Returns the cycle of the first observed pmem_resp, or -1 on timeout.
    task automatic wait_resp(input int limit, output int when);
        when = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (pmem_resp) begin
                when = cyc;
                break;
            end
        end
    endtask

    // Whole transaction on the LATENCY=8 instance, request dropped after RESP.
    task automatic txn(input string tag, input logic wr, input logic [31:0] a,
                       input logic [255:0] d, input logic [255:0] exp_rdata);
        step();
        drive_req(!wr, wr, a, d);
        wait_resp(40, at);
        check({tag, "_lat"}, 256'(at - t_start), 256'(9));
        check({tag, "_rdata"}, pmem_rdata, exp_rdata);
        step();
        drive_req(1'b0, 1'b0, 32'h0, '0);
        @(negedge clk);
        check({tag, "_one_cycle"}, 256'(pmem_resp), 256'(0));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_resp", 256'(pmem_resp), 256'(0));
        check("rst_rdata", pmem_rdata, 256'(0));
        check("rst_prot", 256'(prot_err), 256'(0));
        step();
        rst = 1'b1;

        // Known contents for index 3 before the aborted write
        txn("prefill3", 1'b1, 32'h0000_0060, D_P3, 256'(0));
        // Write 0xA5.. to 0x40 (index 2); rdata untouched by writes
        txn("wr40", 1'b1, 32'h0000_0040, D_A5, 256'(0));
        txn("rd40", 1'b0, 32'h0000_0040, '0, D_A5);
        txn("rd440_alias", 1'b0, 32'h0000_0440, '0, D_A5);

        // Write-back then allocate, switching requests the cycle after resp
        step();
        drive_req(1'b0, 1'b1, 32'h0000_0080, D_WB);
        t_first = t_start;
        wait_resp(40, at);
        check("wb_lat", 256'(at - t_first), 256'(9));
        check("wb_rdata_hold", pmem_rdata, D_A5);
        step();
        drive_req(1'b1, 1'b0, 32'h0000_0040, '0);
        wait_resp(40, at);
        check("alloc_lat", 256'(at - t_first), 256'(19));
        check("alloc_rdata", pmem_rdata, D_A5);
        step();
        drive_req(1'b0, 1'b0, 32'h0, '0);
        txn("rd80", 1'b0, 32'h0000_0080, '0, D_WB);
        check("clean_prot", 256'(prot_err), 256'(0));

        // Both requests high for 3 cycles: refused
        step();
        drive_req(1'b1, 1'b1, 32'h0000_0040, D_FF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("both_no_resp", 256'(pmem_resp), 256'(0));
        end
        step();
        drive_req(1'b0, 1'b0, 32'h0, '0);
        repeat (12) begin
            @(negedge clk);
            check("both_still_idle", 256'(pmem_resp), 256'(0));
        end
        check("both_prot", 256'(prot_err), 256'(CHECK_EN));

        // Reset mid-ACCESS of a write of all-ones to index 3
        step();
        drive_req(1'b0, 1'b1, 32'h0000_0060, D_FF);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_resp", 256'(pmem_resp), 256'(0));
        end
        rst = 1'b0;
        #1;
        check("abort_rst_resp", 256'(pmem_resp), 256'(0));
        check("abort_rst_rdata", pmem_rdata, 256'(0));
        check("abort_rst_prot", 256'(prot_err), 256'(0));
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_resp", 256'(pmem_resp), 256'(0));
        end
        step();
        drive_req(1'b0, 1'b0, 32'h0, '0);
        rst = 1'b1;
        txn("rd3_after_abort", 1'b0, 32'h0000_0060, '0, D_P3);

        // LATENCY=1 instance: write, then read with the request dropped in ACCESS
        step();
        l1_write   = 1'b1;
        l1_address = 32'h0000_00A0;
        l1_wdata   = D_L1;
        t_start    = cyc;
        at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (l1_resp) begin
                at = cyc;
                break;
            end
        end
        check("l1_wr_lat", 256'(at - t_start), 256'(2));
        step();
        l1_write = 1'b0;
        l1_read  = 1'b1;
        t_start  = cyc;
        step();
        l1_read = 1'b0;
        at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (l1_resp) begin
                at = cyc;
                break;
            end
        end
        check("l1_rd_lat", 256'(at - t_start), 256'(2));
        check("l1_rd_data", l1_rdata, D_L1);
        @(negedge clk);
        check("l1_one_cycle", 256'(l1_resp), 256'(0));
        check("l1_prot", 256'(l1_prot_err), 256'(CHECK_EN));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
